sm_fetch_queue: RTL and testbench

Instruction fetch stage for the schoolRISCV core, sitting directly upstream of the combinational instruction ROM. It owns the PC register and drives the ROM word address. It captures the returned instruction word, together with its PC, into a small FIFO, and presents it to decode through a valid/ready handshake. Branch/jump redirects flush the FIFO and reload the PC.

---
 rtl/sm_fetch_queue.sv | 122 ++++++++++++
 tb/tb_sm_fetch_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sm_fetch_queue.sv
// sm_fetch_queue: instruction fetch stage in front of the schoolRISCV
// combinational instruction ROM.
//
// The stage owns the PC and drives the ROM word address. Each cycle it can
// capture the returned word and its PC into a small circular FIFO. Decode
// reads the FIFO head through a valid/ready handshake. A redirect flushes
// the FIFO and reloads the PC.
//
// Handshake: the head is consumed on a cycle where out_valid && out_ready is
// seen at the rising edge, unless redirect_valid is also high; in that case
// the flush wins and nothing is consumed. out_valid never depends
// combinationally on out_ready. While out_valid is high the head stays
// stable until it is consumed or flushed.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   imem_addr         ROM word address = pc >> 2
//   imem_rd           ROM data for imem_addr, same cycle
//   redirect_valid/pc request a PC change (low two bits ignored)
//   out_valid/ready   head handshake toward decode
//   out_instr/pc/err  head entry; all zero while the FIFO is empty
//   level             current FIFO occupancy
module sm_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_SIZE = 64,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rd,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic        mem_err   [DEPTH];

  logic pop;
  logic push;
  logic fetch_err;

  assign imem_addr = {2'b00, pc_q[31:2]};
  assign fetch_err = (imem_addr >= ROM_SIZE);

  assign out_valid = (level_q != '0);
  // A flush discards the head, so it never counts as consumed.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  // A full FIFO may still accept a word when the head leaves the same cycle.
  assign push = ~redirect_valid & ((level_q < LW'(DEPTH)) | pop);

  always_comb begin
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h0000_0003;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible while level_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_q]    <= pc_q;
      mem_instr[wr_q] <= fetch_err ? NOP : imem_rd;
      mem_err[wr_q]   <= fetch_err;
    end
  end

  assign out_pc    = out_valid ? mem_pc[rd_q]    : 32'd0;
  assign out_instr = out_valid ? mem_instr[rd_q] : 32'd0;
  assign out_err   = out_valid & mem_err[rd_q];
  assign level     = level_q;

endmodule

// File: tb/tb_sm_fetch_queue.sv
module tb_sm_fetch_queue;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_err;
  logic [1:0]  level;

  // ROM model: word i holds 0x1000_0000 + i; out-of-range reads return junk.
  assign imem_rd = (imem_addr < 32'd64) ? (32'h1000_0000 + imem_addr) : 32'hDEAD_BEEF;

  sm_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .ROM_SIZE (64),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_err        (out_err),
    .level          (level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Each vector: inputs held during the cycle, expected outputs before its edge.
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_err;
    logic [1:0]  e_level;
    logic [31:0] e_addr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v.e_valid});
    check({tag, ".pc"},    out_pc,             v.e_pc);
    check({tag, ".instr"}, out_instr,          v.e_instr);
    check({tag, ".err"},   {31'd0, out_err},   {31'd0, v.e_err});
    check({tag, ".level"}, {30'd0, level},     {30'd0, v.e_level});
    check({tag, ".addr"},  imem_addr,          v.e_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //             rv   rpc            rdy  val  pc             instr          err  lvl  addr
    // free run from reset
    vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'd0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b0, 2'd1, 32'd1};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1000_0001, 1'b0, 2'd1, 32'd2};
    // backpressure fills the FIFO, then a full pop+push
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h1000_0002, 1'b0, 2'd1, 32'd3};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h1000_0002, 1'b0, 2'd2, 32'd4};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h1000_0002, 1'b0, 2'd2, 32'd4};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h1000_0002, 1'b0, 2'd2, 32'd4};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h1000_0003, 1'b0, 2'd2, 32'd5};
    // redirect with full FIFO and out_ready=1, misaligned target
    vecs[8]  = '{1'b1, 32'h23,        1'b1, 1'b1, 32'h10,        32'h1000_0004, 1'b0, 2'd2, 32'd6};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'd8};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        32'h1000_0008, 1'b0, 2'd1, 32'd9};
    // last in-range word, then out-of-range
    vecs[11] = '{1'b1, 32'd252,       1'b0, 1'b1, 32'h20,        32'h1000_0008, 1'b0, 2'd2, 32'd10};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'd63};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'd252,       32'h1000_003F, 1'b0, 2'd1, 32'd64};
    vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'd252,       32'h1000_003F, 1'b0, 2'd2, 32'd65};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'd256,       32'h0000_0013, 1'b1, 2'd2, 32'd66};
    // redirect held for two cycles
    vecs[16] = '{1'b1, 32'h4,         1'b1, 1'b1, 32'd260,       32'h0000_0013, 1'b1, 2'd2, 32'd67};
    vecs[17] = '{1'b1, 32'h10,        1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'd1};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'd4};
    vecs[19] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        32'h1000_0004, 1'b0, 2'd1, 32'd5};
    // PC wrap past 2^32
    vecs[20] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h14,        32'h1000_0005, 1'b0, 2'd1, 32'd6};
    vecs[21] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 2'd0, 32'h3FFF_FFFF};
    vecs[22] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 2'd1, 32'd0};
    vecs[23] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 2'd2, 32'd1};
    vecs[24] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b0, 2'd2, 32'd2};

    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Values while reset is held.
    @(negedge clk);
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.level", {30'd0, level},     32'd0);
    check("rst.addr",  imem_addr,          32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      out_ready      = v.rdy;
      check_outputs($sformatf("v%0d", i), v);
      @(negedge clk);
    end

    // Async reset mid-cycle while the FIFO is full (level 2 after v24).
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("pre_arst.level", {30'd0, level}, 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.level", {30'd0, level},     32'd0);
    check("arst.addr",  imem_addr,          32'd0);
    check("arst.pc",    out_pc,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_rel.valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("arst_first.valid", {31'd0, out_valid}, 32'd1);
    check("arst_first.pc",    out_pc,             32'd0);
    check("arst_first.instr", out_instr,          32'h1000_0000);
    check("arst_first.level", {30'd0, level},     32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
